ofmap_reader: RTL and testbench

Streams the finished activation map out of BRAM2 (the activation-map buffer the GEMM writes) after a layer completes. On a start pulse it reads all MEM2_DEPTH words in address order through the BRAM2 read port and presents them on a valid/ready stream toward the next layer's loader or the host DMA. A 2-entry output buffer absorbs the 1-cycle BRAM latency and downstream backpressure.

---
 rtl/ofmap_pkg.sv | 14 +
 rtl/ofmap_out_fifo.sv | 53 +++++
 rtl/ofmap_reader.sv | 120 ++++++++++++
 tb/tb_ofmap_reader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofmap_pkg.sv
// Shared types for the BRAM2 activation-map streamer (ofmap_reader).
package ofmap_pkg;

   localparam int unsigned BUF_DEPTH = 2;
   localparam int unsigned CNT_WIDTH = $clog2(BUF_DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/ofmap_out_fifo.sv
// Two-entry output buffer (head + spare register) with registered outputs.
// Entries are {last, data}; the head holds still until it is popped.
module ofmap_out_fifo
   import ofmap_pkg::*;
#(
   parameter int unsigned WIDTH = 113
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [WIDTH-1:0]     push_data,
   input  logic                 pop,
   output logic [WIDTH-1:0]     head_data,
   output logic                 head_valid,
   output logic [CNT_WIDTH-1:0] count
);

   logic [WIDTH-1:0] spare_data;
   logic             spare_valid;
   logic             pop_ok;

   assign pop_ok = pop & head_valid;
   assign count  = CNT_WIDTH'(head_valid) + CNT_WIDTH'(spare_valid);

   // Spare refills the head on a pop; a push lands in the first free slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head_data   <= '0;
         head_valid  <= 1'b0;
         spare_data  <= '0;
         spare_valid <= 1'b0;
      end else if (pop_ok) begin
         if (spare_valid) begin
            head_data   <= spare_data;
            head_valid  <= 1'b1;
            spare_valid <= push;
            if (push) spare_data <= push_data;
         end else begin
            head_valid <= push;
            if (push) head_data <= push_data;
         end
      end else if (push) begin
         if (!head_valid) begin
            head_data  <= push_data;
            head_valid <= 1'b1;
         end else begin
            spare_data  <= push_data;
            spare_valid <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/ofmap_reader.sv
// Streams MEM2_DEPTH words out of BRAM2 onto a valid/ready stream after a start pulse.
// Optional macro OFMAP_READER_RELU_EN zeroes negative signed elements at the buffer input.
module ofmap_reader
   import ofmap_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = 8,
   parameter int unsigned PE_SIZE         = 14,
   parameter int unsigned MEM2_DEPTH      = 896,
   parameter int unsigned MEM2_DATA_WIDTH = 112,
   parameter int unsigned MEM2_ADDR_WIDTH = 10
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start_i,
   output logic                       mem2_ce0,
   output logic                       mem2_we0,
   output logic [MEM2_ADDR_WIDTH-1:0] mem2_addr0,
   input  logic [MEM2_DATA_WIDTH-1:0] mem2_q0_i,
   output logic [MEM2_DATA_WIDTH-1:0] out_data_o,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic                       out_last_o,
   output logic                       busy_o,
   output logic                       done_o
);

   localparam int unsigned ENTRY_WIDTH = MEM2_DATA_WIDTH + 1;
   localparam int unsigned CREDIT_W    = CNT_WIDTH + 1;
   localparam logic [MEM2_ADDR_WIDTH-1:0] LAST_ADDR = MEM2_ADDR_WIDTH'(MEM2_DEPTH - 1);

`ifdef OFMAP_READER_RELU_EN
   localparam bit RELU_EN = 1'b1;
`else
   localparam bit RELU_EN = 1'b0;
`endif

   state_t                      state, state_nxt;
   logic [MEM2_ADDR_WIDTH-1:0]  addr;
   logic                        inflight, inflight_last;
   logic [CNT_WIDTH-1:0]        count;
   logic [CREDIT_W-1:0]         credit_c;
   logic                        pop_c, issue_c, busy_nxt, done_nxt;
   logic [MEM2_DATA_WIDTH-1:0]  push_word_c;
   logic [ENTRY_WIDTH-1:0]      head;

   // Buffer slots already claimed after this cycle's pop; a new read needs a free one.
   assign pop_c    = out_valid_o & out_ready_i;
   assign credit_c = CREDIT_W'(count) + CREDIT_W'(inflight) - CREDIT_W'(pop_c);
   assign issue_c  = (state == READ) && (credit_c < CREDIT_W'(BUF_DEPTH));

   assign mem2_ce0   = issue_c;
   assign mem2_we0   = 1'b0;
   assign mem2_addr0 = addr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_i) state_nxt = READ;
         READ:    if (issue_c && (addr == LAST_ADDR)) state_nxt = DRAIN;
         DRAIN:   if (pop_c && out_last_o) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy_nxt = 1'b0;
      done_nxt = 1'b0;
      if ((state_nxt == READ) || (state_nxt == DRAIN)) busy_nxt = 1'b1;
      if (state_nxt == DONE) done_nxt = 1'b1;
   end

   // Address counter, in-flight read tracking and registered status flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr          <= '0;
         inflight      <= 1'b0;
         inflight_last <= 1'b0;
         busy_o        <= 1'b0;
         done_o        <= 1'b0;
      end else begin
         inflight      <= issue_c;
         inflight_last <= issue_c && (addr == LAST_ADDR);
         busy_o        <= busy_nxt;
         done_o        <= done_nxt;
         if ((state == IDLE) && start_i) addr <= '0;
         else if (issue_c)               addr <= addr + MEM2_ADDR_WIDTH'(1);
      end
   end

   always_comb begin
      push_word_c = mem2_q0_i;
      for (int unsigned i = 0; i < PE_SIZE; i++) begin
         if (RELU_EN && mem2_q0_i[i*DATA_WIDTH + DATA_WIDTH - 1])
            push_word_c[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
   end

   ofmap_out_fifo #(
      .WIDTH(ENTRY_WIDTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight),
      .push_data ({inflight_last, push_word_c}),
      .pop       (pop_c),
      .head_data (head),
      .head_valid(out_valid_o),
      .count     (count)
   );

   assign out_data_o = head[MEM2_DATA_WIDTH-1:0];
   assign out_last_o = head[MEM2_DATA_WIDTH];

endmodule

// File: tb/tb_ofmap_reader.sv
// Bench for ofmap_reader: BRAM2 model, stream monitor and a word-level reference model.
module tb_ofmap_reader;

   localparam int unsigned DW    = 8;
   localparam int unsigned PE    = 14;
   localparam int unsigned DEPTH = 896;
   localparam int unsigned MDW   = PE * DW;
   localparam int unsigned AW    = 10;

   logic           clk = 1'b0;
   logic           rst, start_i, out_ready_i;
   logic           mem2_ce0, mem2_we0, out_valid_o, out_last_o, busy_o, done_o;
   logic [AW-1:0]  mem2_addr0;
   logic [MDW-1:0] mem2_q0_i, out_data_o;

   // Second instance with a one-word map, always ready
   logic           ce1, we1, valid1, last1, busy1, done1;
   logic [AW-1:0]  addr1;
   logic [MDW-1:0] q1, data1;

   always #5 clk = ~clk;

   ofmap_reader #(.DATA_WIDTH(DW), .PE_SIZE(PE), .MEM2_DEPTH(DEPTH),
                  .MEM2_DATA_WIDTH(MDW), .MEM2_ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .start_i(start_i),
      .mem2_ce0(mem2_ce0), .mem2_we0(mem2_we0), .mem2_addr0(mem2_addr0),
      .mem2_q0_i(mem2_q0_i), .out_data_o(out_data_o), .out_valid_o(out_valid_o),
      .out_ready_i(out_ready_i), .out_last_o(out_last_o), .busy_o(busy_o), .done_o(done_o));

   ofmap_reader #(.DATA_WIDTH(DW), .PE_SIZE(PE), .MEM2_DEPTH(1),
                  .MEM2_DATA_WIDTH(MDW), .MEM2_ADDR_WIDTH(AW)) dut1 (
      .clk(clk), .rst(rst), .start_i(start_i),
      .mem2_ce0(ce1), .mem2_we0(we1), .mem2_addr0(addr1),
      .mem2_q0_i(q1), .out_data_o(data1), .out_valid_o(valid1),
      .out_ready_i(1'b1), .out_last_o(last1), .busy_o(busy1), .done_o(done1));

   logic [MDW-1:0] bram [DEPTH];
   always @(posedge clk) if (mem2_ce0) mem2_q0_i <= bram[int'(mem2_addr0)];
   always @(posedge clk) if (ce1) q1 <= bram[int'(addr1)];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int ready_mode = 0;  // 0: always ready, 1: random 50%, 2: never ready
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_ready_i = 1'b1;
         1:       out_ready_i = ($urandom_range(0, 1) == 1);
         default: out_ready_i = 1'b0;
      endcase
   end

   // Reference: stream is bram[0..DEPTH-1] in order, each element clamped at 0 when ReLU is on
   function automatic logic [MDW-1:0] expect_word(input logic [MDW-1:0] w);
      logic [MDW-1:0] r;
      r = w;
`ifdef OFMAP_READER_RELU_EN
      for (int i = 0; i < int'(PE); i++)
         if ($signed(w[i*DW +: DW]) < 0) r[i*DW +: DW] = '0;
`endif
      return r;
   endfunction

   // Stream monitor
   logic [MDW-1:0] got_data [$];
   bit             got_last [$];
   int             got_cyc  [$];
   int             ce_addr  [$];
   int  start_cyc = 0, rel;
   int  ce_cnt, ce_first, busy_first, done_cnt, done_cyc, we_seen, stab_err;
   int  s1_beats, s1_last, s1_done, s1_bad;
   bit  mon_clear = 1'b0;
   bit  prev_stall = 1'b0;
   logic [MDW-1:0] prev_data;
   logic prev_last;

   always @(negedge clk) begin
      rel = cyc - start_cyc;
      if (mon_clear) begin
         got_data.delete(); got_last.delete(); got_cyc.delete(); ce_addr.delete();
         ce_cnt = 0; ce_first = -1; busy_first = -1; done_cnt = 0; done_cyc = -1;
         we_seen = 0; stab_err = 0; s1_beats = 0; s1_last = 0; s1_done = 0; s1_bad = 0;
      end else if (!rst) begin
         if (out_valid_o && out_ready_i) begin
            got_data.push_back(out_data_o); got_last.push_back(out_last_o); got_cyc.push_back(rel);
         end
         if (mem2_ce0) begin
            ce_cnt++; ce_addr.push_back(int'(mem2_addr0));
            if (ce_first < 0) ce_first = rel;
         end
         if (busy_o && busy_first < 0) busy_first = rel;
         if (done_o) begin done_cnt++; done_cyc = rel; end
         if (mem2_we0 || we1) we_seen++;
         if (prev_stall && (!out_valid_o || out_data_o !== prev_data || out_last_o !== prev_last))
            stab_err++;
         if (valid1) begin
            s1_beats++;
            if (last1) s1_last++;
            if (data1 !== expect_word(bram[0])) s1_bad++;
         end
         if (done1) s1_done++;
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_data  = out_data_o;
      prev_last  = out_last_o;
   end

   int n_tests = 0, n_fail = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check_word(input string name, input logic [MDW-1:0] act, input logic [MDW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_ce0"},   longint'(mem2_ce0), 0);
      check({tag, "_we0"},   longint'(mem2_we0), 0);
      check({tag, "_addr"},  longint'(mem2_addr0), 0);
      check_word({tag, "_data"}, out_data_o, '0);
      check({tag, "_valid"}, longint'(out_valid_o), 0);
      check({tag, "_last"},  longint'(out_last_o), 0);
      check({tag, "_busy"},  longint'(busy_o), 0);
      check({tag, "_done"},  longint'(done_o), 0);
   endtask

   task automatic clear_mon();
      @(posedge clk); #1 mon_clear = 1'b1;
      @(posedge clk); #1 mon_clear = 1'b0;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1; start_cyc = cyc; start_i = 1'b1;
      @(posedge clk); #1; start_i = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (done_cnt == 0 && n < budget) begin @(posedge clk); n++; end
      check({tag, "_done_seen"}, longint'(done_cnt > 0), 1);
      repeat (4) @(posedge clk);
   endtask

   task automatic wait_beats(input string tag, input int nb, input int budget);
      int n;
      n = 0;
      while (got_data.size() < nb && n < budget) begin @(posedge clk); n++; end
      check({tag, "_reached_beat"}, longint'(got_data.size() >= nb), 1);
   endtask

   task automatic verify(input string tag);
      int mism, lasts, lastpos;
      mism = 0; lasts = 0; lastpos = -1;
      check({tag, "_beats"}, got_data.size(), DEPTH);
      for (int i = 0; i < got_data.size(); i++) begin
         if (i >= int'(DEPTH) || got_data[i] !== expect_word(bram[i])) mism++;
         if (got_last[i]) begin lasts++; lastpos = i; end
      end
      check({tag, "_data_order"}, mism, 0);
      check({tag, "_last_count"}, lasts, 1);
      check({tag, "_last_pos"}, lastpos, DEPTH - 1);
      check({tag, "_done_once"}, done_cnt, 1);
      check({tag, "_we0_never"}, we_seen, 0);
      check({tag, "_hold_stable"}, stab_err, 0);
   endtask

   typedef struct { int beat; int cyc; bit last; } beat_vec_t;
   typedef struct { int addr; logic [7:0] e0; logic [7:0] e1; logic [7:0] x0; logic [7:0] x1; } relu_vec_t;

   beat_vec_t bv [5];
   relu_vec_t rv [3];

   initial begin
      logic [MDW-1:0] w;
      rst = 1'b1; start_i = 1'b0;

      bv[0] = '{0, 3, 1'b0};
      bv[1] = '{1, 4, 1'b0};
      bv[2] = '{100, 103, 1'b0};
      bv[3] = '{894, 897, 1'b0};
      bv[4] = '{895, 898, 1'b1};
`ifdef OFMAP_READER_RELU_EN
      rv[0] = '{10, 8'h80, 8'h7F, 8'h00, 8'h7F};
      rv[1] = '{11, 8'hFF, 8'h01, 8'h00, 8'h01};
      rv[2] = '{12, 8'h00, 8'h81, 8'h00, 8'h00};
`else
      rv[0] = '{10, 8'h80, 8'h7F, 8'h80, 8'h7F};
      rv[1] = '{11, 8'hFF, 8'h01, 8'hFF, 8'h01};
      rv[2] = '{12, 8'h00, 8'h81, 8'h00, 8'h81};
`endif
      for (int a = 0; a < int'(DEPTH); a++)
         for (int i = 0; i < int'(PE); i++)
            bram[a][i*DW +: DW] = 8'(a + 37 * i);
      for (int i = 0; i < 3; i++) begin
         bram[rv[i].addr][7:0]  = rv[i].e0;
         bram[rv[i].addr][15:8] = rv[i].e1;
      end

      repeat (3) @(posedge clk);
      #1 check_idle("reset");
      @(negedge clk) rst = 1'b0;

      // Always ready: full-rate stream and cycle timing
      ready_mode = 0;
      clear_mon();
      pulse_start();
      wait_done("rdy", 3000);
      verify("rdy");
      check("rdy_first_ce_cycle", ce_first, 1);
      check("rdy_busy_cycle", busy_first, 1);
      check("rdy_done_cycle", done_cyc, 899);
      for (int i = 0; i < 5; i++) begin
         check($sformatf("rdy_beat%0d_cycle", bv[i].beat),
               (bv[i].beat < got_cyc.size()) ? got_cyc[bv[i].beat] : -1, bv[i].cyc);
         check($sformatf("rdy_beat%0d_last", bv[i].beat),
               (bv[i].beat < got_last.size()) ? longint'(got_last[bv[i].beat]) : -1, longint'(bv[i].last));
      end
      for (int i = 0; i < 3; i++) begin
         w = (rv[i].addr < got_data.size()) ? got_data[rv[i].addr] : 'x;
         check($sformatf("relu_a%0d_e0", rv[i].addr), longint'(w[7:0]), longint'(rv[i].x0));
         check($sformatf("relu_a%0d_e1", rv[i].addr), longint'(w[15:8]), longint'(rv[i].x1));
      end
      check("depth1_beats", s1_beats, 1);
      check("depth1_last", s1_last, 1);
      check("depth1_data_bad", s1_bad, 0);
      check("depth1_done", s1_done, 1);

      // Backpressure: ready low for 20 cycles, then released
      ready_mode = 2;
      clear_mon();
      pulse_start();
      repeat (18) @(posedge clk);
      @(negedge clk);
      check("bp_ce_count", ce_cnt, 2);
      check("bp_ce_addr0", (ce_addr.size() > 0) ? ce_addr[0] : -1, 0);
      check("bp_ce_addr1", (ce_addr.size() > 1) ? ce_addr[1] : -1, 1);
      check("bp_valid_held", longint'(out_valid_o), 1);
      check_word("bp_word0_held", out_data_o, expect_word(bram[0]));
      check("bp_no_beats", got_data.size(), 0);
      ready_mode = 0;
      wait_done("bp", 3000);
      verify("bp");

      // Random ready with a stray start pulse mid-stream
      ready_mode = 1;
      clear_mon();
      pulse_start();
      wait_beats("rs", 100, 3000);
      @(posedge clk); #1 start_i = 1'b1;
      @(posedge clk); #1 start_i = 1'b0;
      wait_done("rs", 5000);
      verify("rs");

      // Reset mid-stream, then a fresh stream from address 0
      clear_mon();
      pulse_start();
      wait_beats("mr", 300, 3000);
      #2 rst = 1'b1;
      #1 check_idle("midrst");
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      clear_mon();
      pulse_start();
      wait_done("mr", 5000);
      verify("mr");
      check("mr_first_ce_addr", (ce_addr.size() > 0) ? ce_addr[0] : -1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
